// File: rtl/uma_bus_pkg.sv
// Shared constants for the UMA bus arbiter: FSM state encoding, the data
// word returned on a memory-ack watchdog timeout, and the master-index width.
package uma_bus_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_CAPT   = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uma_rr_picker.sv
// Round-robin picker: returns the first requesting index at or above rr_ptr,
// wrapping modulo N. Purely combinational.
import uma_bus_pkg::*;

module uma_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int c;
            c = (int'(rr_ptr) + k) % N;
            if (req[c]) idx = IW'(c);
        end
    end

endmodule

// File: rtl/uma_bus_arbiter.sv
// Round-robin arbiter between NUM_MASTERS L1 direct loaders and one
// single-port memory req/ack interface; one transfer in flight at a time.
// Optional memory-ack watchdog enabled by defining ARB_TIMEOUT_EN.
import uma_bus_pkg::*;

module uma_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_rreq,
    input  logic [NUM_MASTERS-1:0]    m_wreq,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_acc,
    output logic [NUM_MASTERS-1:0]    m_busy,
    output logic [31:0]               m_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ack,
    output logic                      err
);

    localparam int IW = idx_width(NUM_MASTERS);

    logic [2:0]             state;
    logic [IW-1:0]          gnt;
    logic [IW-1:0]          rr_ptr;
    logic                   is_wr;
    logic [NUM_MASTERS-1:0] req;
    logic                   pick_vld;
    logic [IW-1:0]          pick;
    logic                   tmo_hit;

    assign req = m_rreq | m_wreq;

    uma_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .idx    (pick)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_cnt;

    // Fires in the ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else if (state == ST_CAPT) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (!mem_ack && tmo_hit) err <= 1'b1;
        end
    end
`else
    wire unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit  = 1'b0;
    assign err      = 1'b0;
`endif

    // Transfer sequencer: grant, capture the master's address, run the
    // memory access, then release the master and advance the RR pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            is_wr     <= 1'b0;
            m_acc     <= '0;
            m_busy    <= '0;
            m_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt          <= pick;
                        // Read wins when a master raises both requests.
                        is_wr        <= m_wreq[pick] & ~m_rreq[pick];
                        m_acc[pick]  <= 1'b1;
                        m_busy[pick] <= m_rreq[pick];
                        state        <= ST_GRANT;
                    end
                end
                ST_GRANT: state <= ST_CAPT;
                ST_CAPT: begin
                    mem_addr  <= m_addr[32*gnt +: 32];
                    mem_wdata <= m_wdata[32*gnt +: 32];
                    mem_we    <= is_wr;
                    mem_req   <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (mem_ack || tmo_hit) begin
                        mem_req     <= 1'b0;
                        m_acc[gnt]  <= 1'b0;
                        m_busy[gnt] <= 1'b0;
                        if (!is_wr) m_rdata <= mem_ack ? mem_rdata : BAD_DATA;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_ptr <= (gnt == IW'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uma_bus_arbiter.md
Name: uma_bus_arbiter

Overview:
- Sits directly downstream of the L1 direct loaders. Each loader is a bus master using the bus_rreq/bus_wreq/bus_acc/bus_busy handshake.
- Arbitrates NUM_MASTERS loaders round-robin onto one single-port memory request/acknowledge interface.
- Serves one transfer at a time: grants the master, captures its registered addr/wdata, issues the memory access, then returns read data and releases the master.

Parameters:
- NUM_MASTERS, 2, number of loader ports (2..8)
- TIMEOUT_CYCLES, 255, memory-ack watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_rreq  in  NUM_MASTERS  per-master read request (loader bus_rreq)
- m_wreq  in  NUM_MASTERS  per-master write request (loader bus_wreq)
- m_addr  in  32*NUM_MASTERS  per-master address, slice i = [32i+31:32i]
- m_wdata  in  32*NUM_MASTERS  per-master write data, same slicing
- m_acc  out  NUM_MASTERS  per-master grant (loader bus_acc)
- m_busy  out  NUM_MASTERS  per-master read-in-progress (loader bus_busy)
- m_rdata  out  32  read data, broadcast to all masters
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  read data, valid in the mem_ack cycle
- mem_ack  in  1  single-cycle completion pulse
- err  out  1  sticky timeout flag; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- All outputs are registered.
- Reset values: m_acc=0, m_busy=0, m_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, state=IDLE, rr_ptr=0.
- Reset asserted mid-transfer aborts immediately; no memory access completes afterwards.

States:
- IDLE
  - req_i = m_rreq[i] | m_wreq[i].
  - Pick the first requesting i scanning from rr_ptr upward, modulo NUM_MASTERS.
  - If m_rreq[i] and m_wreq[i] are both set, the read wins.
  - On a pick: latch gnt=i and is_wr, set m_acc[i]=1, set m_busy[i]=1 (reads only), go to GRANT.
  - No requests: stay in IDLE.
- GRANT (1 cycle): the master sees acc, then registers addr/wdata and drops its request. Go to CAPT.
- CAPT (1 cycle): sample m_addr/m_wdata slice gnt into mem_addr/mem_wdata; mem_we=is_wr; mem_req=1. Go to ACCESS.
- ACCESS: wait for mem_ack; mem_req stays high.
  - On ack: mem_req=0; m_acc[gnt]=0; m_busy[gnt]=0; if read, m_rdata=mem_rdata. Go to DONE.
- DONE (1 cycle): rr_ptr=(gnt+1) mod NUM_MASTERS. Go to IDLE.
  - This guarantees the finished master's request is low before the next arbitration.

Timing:
- Request seen in cycle T0: m_acc high T1; mem_req high T3; ack in T3 at the earliest; m_busy/m_acc low and m_rdata valid in T4.
- A loader in its read-wait state samples m_rdata at the end of T4.
- m_busy is already high when the loader first checks it (T3).
- For writes, m_acc stays high until after ack. The loader's wait-for-~acc then completes.
- Unselected masters hold their requests with no acc; they are served after the current transfer.
- Fairness: with all masters continuously requesting, grant order is 0,1,…,N-1,0…
- mem_ack outside ACCESS is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- With it:
  - An 8+-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without ack, the transfer ends as if acked:
    - mem_req=0
    - m_rdata=32'hDEADBEEF for reads
    - err=1, sticky until reset
  - Go to DONE.
- Without it: no counter; ACCESS waits forever; err is constant 0.

Decomposition:
- Package uma_bus_pkg: state encoding constants (IDLE, GRANT, CAPT, ACCESS, DONE, 3 bits), the 32'hDEADBEEF bad-data constant, and a clog2-based master-index width.
- One sub-module, uma_rr_picker: combinational; inputs are the req vector and rr_ptr; outputs are valid and the chosen index.

Test Plan:
- Single read, master 0, addr 0x1000, memory acks 2 cycles after mem_req with 0xCAFEF00D -> mem_addr=0x1000, mem_we=0; m_busy[0] falls in the cycle after ack with m_rdata=0xCAFEF00D; loader returns 0xCAFEF00D.
- Single write, master 1, addr 0x2004, data 0x12345678 -> mem_we=1, mem_wdata=0x12345678; m_acc[1] falls the cycle after ack; no m_busy assertion.
- Masters 0 and 1 issue reads in the same cycle, rr_ptr=0 -> master 0 served first, master 1 second; each gets its own data (0xAAAA0000, 0xBBBB1111).
- Both masters request continuously for 6 transfers -> grant order 0,1,0,1,0,1.
- Reset asserted in ACCESS with mem_req high -> the next cycle shows every output at its reset value; ack is ignored afterwards.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> after 8 ACCESS cycles m_rdata=0xDEADBEEF and err=1; a later normal read still completes and err stays 1.
